// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pattern pipeline: active area, tile grid,
// pattern mode encodings, the colour-bar table and the cursor colour.
package lcd_pkg;

    localparam logic [9:0] H_ACTIVE  = 10'd480;
    localparam logic [9:0] V_ACTIVE  = 10'd272;
    localparam logic [5:0] TILE_COLS = 6'd60;
    localparam logic [5:0] TILE_ROWS = 6'd34;
    localparam int         TILE_LOG2 = 3;

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_GRAD    = 2'd2,
        MODE_BLACK   = 2'd3
    } mode_t;

    localparam logic [15:0] CURSOR_COLOR = 16'hF800;

    // 60-px bars picked by a compare chain so no divider is synthesised.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] idx;
        if      (x < 10'd60)  idx = 3'd0;
        else if (x < 10'd120) idx = 3'd1;
        else if (x < 10'd180) idx = 3'd2;
        else if (x < 10'd240) idx = 3'd3;
        else if (x < 10'd300) idx = 3'd4;
        else if (x < 10'd360) idx = 3'd5;
        else if (x < 10'd420) idx = 3'd6;
        else                  idx = 3'd7;
        return idx;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_tile_cursor.sv
// Frame-start detector, frame counter and the 8x8 tile cursor that steps
// once every CURSOR_FRAMES frame starts across a 60x34 tile grid.
module lcd_tile_cursor
    import lcd_pkg::*;
#(
    parameter int CURSOR_FRAMES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vsync,
    output logic        o_frame_start_det,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt,
    output logic [5:0]  o_cursor_x,
    output logic [5:0]  o_cursor_y
);

    localparam logic [7:0] DIV_LAST = 8'(CURSOR_FRAMES - 1);

    logic        r_vsync_prev;
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_div;
    logic [5:0]  r_cursor_x;
    logic [5:0]  r_cursor_y;
    logic        w_frame_start;

    // History resets low, so vsync held low through reset release is not an edge.
    assign w_frame_start = r_vsync_prev & ~i_vsync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsync_prev  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_div         <= 8'd0;
            r_cursor_x    <= 6'd0;
            r_cursor_y    <= 6'd0;
        end else begin
            r_vsync_prev  <= i_vsync;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (r_div == DIV_LAST) begin
                    r_div <= 8'd0;
                    if (r_cursor_x == TILE_COLS - 6'd1) begin
                        r_cursor_x <= 6'd0;
                        r_cursor_y <= (r_cursor_y == TILE_ROWS - 6'd1) ? 6'd0 : r_cursor_y + 6'd1;
                    end else begin
                        r_cursor_x <= r_cursor_x + 6'd1;
                    end
                end else begin
                    r_div <= r_div + 8'd1;
                end
            end
        end
    end

    assign o_frame_start_det = w_frame_start;
    assign o_frame_start     = r_frame_start;
    assign o_frame_cnt       = r_frame_cnt;
    assign o_cursor_x        = r_cursor_x;
    assign o_cursor_y        = r_cursor_y;

endmodule

// File: rtl/lcd_pattern_pipe.sv
// Two-stage LCD pixel pipeline: registers timing inputs, renders one of four
// test patterns with a tile cursor overlay, and keeps syncs aligned with RGB.
module lcd_pattern_pipe
    import lcd_pkg::*;
#(
    parameter int CURSOR_FRAMES = 1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_en,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic [9:0]  in_pixelx,
    input  logic [9:0]  in_pixely,
    input  logic [1:0]  in_mode,
    output logic        out_en,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [4:0]  out_r,
    output logic [5:0]  out_g,
    output logic [4:0]  out_b,
    output logic        out_frame_start,
    output logic [15:0] out_frame_cnt,
    output logic [5:0]  out_cursor_x,
    output logic [5:0]  out_cursor_y
);

    logic        r1_en;
    logic        r1_hsync;
    logic        r1_vsync;
    logic [9:0]  r1_x;
    logic [9:0]  r1_y;
    logic        r_en;
    logic        r_hsync;
    logic        r_vsync;
    logic [15:0] r_rgb;
    mode_t       r_mode;

    logic        w_frame_start_det;
    logic        w_active;
    logic        w_overlay;
    logic [15:0] w_pat;
    logic [15:0] w_rgb;

    lcd_tile_cursor #(
        .CURSOR_FRAMES(CURSOR_FRAMES)
    ) u_tile_cursor (
        .i_clk             (in_clk),
        .i_rst_n           (in_rst_n),
        .i_vsync           (in_vsync),
        .o_frame_start_det (w_frame_start_det),
        .o_frame_start     (out_frame_start),
        .o_frame_cnt       (out_frame_cnt),
        .o_cursor_x        (out_cursor_x),
        .o_cursor_y        (out_cursor_y)
    );

    assign w_active  = r1_en && (r1_x < H_ACTIVE) && (r1_y < V_ACTIVE);
    assign w_overlay = (r1_x[9:TILE_LOG2] == {1'b0, out_cursor_x}) &&
                       (r1_y[9:TILE_LOG2] == {1'b0, out_cursor_y});

    always_comb begin
        w_pat = 16'h0000;
        case (r_mode)
            MODE_CHECKER: w_pat = {(r1_x[3] ^ r1_y[3]) ? 5'd15 : 5'd0,
                                   (r1_x[4] ^ r1_y[4]) ? 6'd15 : 6'd0,
                                   (r1_x[5] ^ r1_y[5]) ? 5'd15 : 5'd0};
            MODE_BARS:    w_pat = bar_color(bar_index(r1_x));
            MODE_GRAD:    w_pat = {r1_x[8:4], r1_y[8:3], ~r1_x[8:4]};
            default:      w_pat = 16'h0000;
        endcase
        w_rgb = 16'h0000;
        if (w_active) begin
            w_rgb = w_overlay ? CURSOR_COLOR : w_pat;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r1_en    <= 1'b0;
            r1_hsync <= 1'b1;
            r1_vsync <= 1'b1;
            r1_x     <= 10'd0;
            r1_y     <= 10'd0;
            r_en     <= 1'b0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_rgb    <= 16'h0000;
            r_mode   <= MODE_CHECKER;
        end else begin
            r1_en    <= in_en;
            r1_hsync <= in_hsync;
            r1_vsync <= in_vsync;
            r1_x     <= in_pixelx;
            r1_y     <= in_pixely;
            r_en     <= r1_en;
            r_hsync  <= r1_hsync;
            r_vsync  <= r1_vsync;
            r_rgb    <= w_rgb;
            // Mode is latched only on a frame start, so mid-frame changes wait.
            if (w_frame_start_det) begin
                r_mode <= mode_t'(in_mode);
            end
        end
    end

    assign out_en    = r_en;
    assign out_hsync = r_hsync;
    assign out_vsync = r_vsync;
    assign out_r     = r_rgb[15:11];
    assign out_g     = r_rgb[10:5];
    assign out_b     = r_rgb[4:0];

endmodule

// File: tb/tb_lcd_pattern_pipe.sv
// Directed bench for lcd_pattern_pipe: latency, patterns, cursor wrap,
// mode timing and reset behaviour with hand-computed RGB565 expectations.
module tb_lcd_pattern_pipe;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_en;
    logic        in_hsync;
    logic        in_vsync;
    logic [9:0]  in_pixelx;
    logic [9:0]  in_pixely;
    logic [1:0]  in_mode;
    logic        out_en;
    logic        out_hsync;
    logic        out_vsync;
    logic [4:0]  out_r;
    logic [5:0]  out_g;
    logic [4:0]  out_b;
    logic        out_frame_start;
    logic [15:0] out_frame_cnt;
    logic [5:0]  out_cursor_x;
    logic [5:0]  out_cursor_y;
    logic [15:0] rgb;

    int n_assert = 0;
    int n_fail   = 0;

    logic h_en [0:495];
    logic h_hs [0:495];

    lcd_pattern_pipe #(.CURSOR_FRAMES(1)) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_en           (in_en),
        .in_hsync        (in_hsync),
        .in_vsync        (in_vsync),
        .in_pixelx       (in_pixelx),
        .in_pixely       (in_pixely),
        .in_mode         (in_mode),
        .out_en          (out_en),
        .out_hsync       (out_hsync),
        .out_vsync       (out_vsync),
        .out_r           (out_r),
        .out_g           (out_g),
        .out_b           (out_b),
        .out_frame_start (out_frame_start),
        .out_frame_cnt   (out_frame_cnt),
        .out_cursor_x    (out_cursor_x),
        .out_cursor_y    (out_cursor_y)
    );

    always #5 in_clk = ~in_clk;

    assign rgb = {out_r, out_g, out_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one active pixel and wait out the 2-cycle pipeline.
    task automatic pix(input logic [9:0] x, input logic [9:0] y);
        @(negedge in_clk);
        in_en     = 1'b1;
        in_pixelx = x;
        in_pixely = y;
        @(negedge in_clk);
        @(negedge in_clk);
    endtask

    // One vsync falling edge with in_mode presented on the same cycle.
    task automatic fs(input logic [1:0] m);
        @(negedge in_clk);
        in_en    = 1'b0;
        in_vsync = 1'b1;
        @(negedge in_clk);
        in_vsync = 1'b0;
        in_mode  = m;
        @(negedge in_clk);
        in_vsync = 1'b1;
    endtask

    initial begin
        in_rst_n  = 1'b0;
        in_en     = 1'b0;
        in_hsync  = 1'b1;
        in_vsync  = 1'b0;
        in_pixelx = 10'd0;
        in_pixely = 10'd0;
        in_mode   = 2'd0;
        repeat (3) @(negedge in_clk);

        chk("rst_en", out_en, 0);
        chk("rst_hsync", out_hsync, 1);
        chk("rst_vsync", out_vsync, 1);
        chk("rst_rgb", rgb, 16'h0000);
        chk("rst_fs", out_frame_start, 0);
        chk("rst_cnt", out_frame_cnt, 0);
        chk("rst_cx", out_cursor_x, 0);
        chk("rst_cy", out_cursor_y, 0);

        // Release with vsync held low: no frame start may appear.
        in_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge in_clk);
            chk("no_fs_release", out_frame_start, 0);
        end
        chk("no_cnt_release", out_frame_cnt, 0);
        in_vsync = 1'b1;

        // One active line plus a short hsync pulse in the blanking tail.
        for (int i = 0; i < 496; i++) begin
            @(negedge in_clk);
            if (i >= 2) begin
                chk("lat_en", out_en, h_en[i-2]);
                chk("lat_hsync", out_hsync, h_hs[i-2]);
                if (!h_en[i-2]) chk("lat_blank_rgb", rgb, 16'h0000);
            end
            h_en[i]   = (i < 480);
            h_hs[i]   = !(i >= 484 && i < 488);
            in_en     = h_en[i];
            in_hsync  = h_hs[i];
            in_pixelx = 10'(i);
            in_pixely = 10'd5;
        end
        in_en    = 1'b0;
        in_hsync = 1'b1;

        // Checker, cursor at tile (0,0).
        pix(10'd8, 10'd0);     chk("chk_8_0", rgb, 16'h7800);
        pix(10'd3, 10'd3);     chk("cursor_3_3", rgb, 16'hF800);
        pix(10'd40, 10'd0);    chk("chk_40_0", rgb, 16'h780F);
        pix(10'd16, 10'd8);    chk("chk_16_8", rgb, 16'h79E0);
        pix(10'd479, 10'd271); chk("chk_479_271", rgb, 16'h01E0);
        pix(10'd480, 10'd8);   chk("blank_x480", rgb, 16'h0000);
        pix(10'd500, 10'd0);   chk("blank_x500", rgb, 16'h0000);
        pix(10'd16, 10'd272);  chk("blank_y272", rgb, 16'h0000);
        pix(10'd16, 10'd300);  chk("blank_y300", rgb, 16'h0000);

        // Colour bars after one frame start.
        fs(2'd1);
        chk("fs_pulse", out_frame_start, 1);
        chk("fs_cnt1", out_frame_cnt, 1);
        chk("fs_cx1", out_cursor_x, 1);
        chk("fs_cy1", out_cursor_y, 0);
        @(negedge in_clk);
        chk("fs_pulse_end", out_frame_start, 0);
        pix(10'd0, 10'd100);   chk("bar_x0", rgb, 16'hFFFF);
        pix(10'd59, 10'd100);  chk("bar_x59", rgb, 16'hFFFF);
        pix(10'd60, 10'd100);  chk("bar_x60", rgb, 16'hFFE0);
        pix(10'd119, 10'd100); chk("bar_x119", rgb, 16'hFFE0);
        pix(10'd120, 10'd100); chk("bar_x120", rgb, 16'h07FF);
        pix(10'd419, 10'd100); chk("bar_x419", rgb, 16'h001F);
        pix(10'd420, 10'd100); chk("bar_x420", rgb, 16'h0000);

        // Mode change mid-frame is deferred to the next frame start.
        fs(2'd0);
        pix(10'd8, 10'd100);   chk("chk_8_100", rgb, 16'h780F);
        in_mode = 2'd2;
        pix(10'd8, 10'd100);   chk("midframe_hold", rgb, 16'h780F);
        fs(2'd2);
        chk("fs_cnt3", out_frame_cnt, 3);
        pix(10'd8, 10'd100);   chk("grad_8_100", rgb, 16'h019F);
        pix(10'd200, 10'd40);  chk("grad_200_40", rgb, 16'h60B3);

        // New mode presented on the frame-start cycle itself; overlay on black.
        fs(2'd3);
        chk("fs_cx4", out_cursor_x, 4);
        pix(10'd100, 10'd100); chk("black_100", rgb, 16'h0000);
        pix(10'd33, 10'd2);    chk("cursor_black", rgb, 16'hF800);
        pix(10'd40, 10'd2);    chk("cursor_next_tile", rgb, 16'h0000);

        // Cursor stepping and wrap.
        repeat (55) fs(2'd3);
        chk("wrap_cnt59", out_frame_cnt, 59);
        chk("wrap_cx59", out_cursor_x, 59);
        chk("wrap_cy0", out_cursor_y, 0);
        fs(2'd3);
        chk("wrap_cx0", out_cursor_x, 0);
        chk("wrap_cy1", out_cursor_y, 1);
        repeat (1979) fs(2'd3);
        chk("wrap_last_cx", out_cursor_x, 59);
        chk("wrap_last_cy", out_cursor_y, 33);
        fs(2'd3);
        chk("wrap_cnt2040", out_frame_cnt, 2040);
        chk("wrap_home_cx", out_cursor_x, 0);
        chk("wrap_home_cy", out_cursor_y, 0);

        // Asynchronous reset in the middle of an active line.
        in_hsync = 1'b0;
        pix(10'd3, 10'd3);
        chk("pre_rst_en", out_en, 1);
        chk("pre_rst_hsync", out_hsync, 0);
        chk("pre_rst_rgb", rgb, 16'hF800);
        #2;
        in_rst_n = 1'b0;
        in_vsync = 1'b0;
        #1;
        chk("arst_en", out_en, 0);
        chk("arst_hsync", out_hsync, 1);
        chk("arst_vsync", out_vsync, 1);
        chk("arst_rgb", rgb, 16'h0000);
        chk("arst_cnt", out_frame_cnt, 0);
        chk("arst_cx", out_cursor_x, 0);
        chk("arst_fs", out_frame_start, 0);
        in_en    = 1'b0;
        in_hsync = 1'b1;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge in_clk);
            chk("no_fs_rerelease", out_frame_start, 0);
        end
        in_vsync = 1'b1;
        pix(10'd8, 10'd0);     chk("mode_reset_chk", rgb, 16'h7800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_pipe.md
Name: lcd_pattern_pipe

Overview:
- Downstream stage of the 480x272 LCD timing generator. Consumes its enable, syncs and pixel coordinates; drives RGB565 and the re-aligned syncs to the LCD pins.
- Generates four selectable test patterns plus a moving 8x8 tile cursor overlay.
- Runs entirely in the 9 MHz pixel clock domain, so there is no cross-domain sampling of the coordinates.
- Syncs are delayed to match the RGB latency exactly.

Parameters:
- H_ACTIVE, 480, active pixels per line; coordinates >= H_ACTIVE are treated as blank.
- V_ACTIVE, 272, active lines; coordinates >= V_ACTIVE are treated as blank.
- CURSOR_FRAMES, 1, number of frame starts per cursor step (1..255).

Ports:
- in_clk, input, 1, pixel clock (9 MHz).
- in_rst_n, input, 1, asynchronous active-low reset.
- in_en, input, 1, data-enable from the timing generator.
- in_hsync, input, 1, active-low hsync.
- in_vsync, input, 1, active-low vsync.
- in_pixelx, input, 10, current pixel column.
- in_pixely, input, 10, current pixel row.
- in_mode, input, 2, pattern select; sampled only at frame start.
- out_en, output, 1, in_en delayed 2 cycles.
- out_hsync, output, 1, in_hsync delayed 2 cycles.
- out_vsync, output, 1, in_vsync delayed 2 cycles.
- out_r, output, 5, red channel.
- out_g, output, 6, green channel.
- out_b, output, 5, blue channel.
- out_frame_start, output, 1, one-cycle pulse on each detected frame start.
- out_frame_cnt, output, 16, number of frame starts since reset; wraps.
- out_cursor_x, output, 6, cursor tile column (0..59).
- out_cursor_y, output, 6, cursor tile row (0..33).

Behaviour:
- Reset (async assert, sync release) values:
  - out_en = 0; out_hsync = 1; out_vsync = 1; RGB = 0.
  - out_frame_start = 0; out_frame_cnt = 0; cursor = (0,0).
  - Active mode = 0; frame divider = 0; vsync history register = 0.
- Pipeline:
  - Stage 1 registers en, hsync, vsync, x and y.
  - Stage 2 registers syncs/en and the computed RGB.
  - Total latency is 2 cycles for every output channel; syncs and RGB stay cycle-aligned.
- Frame start:
  - Defined as registered previous vsync = 1 and current in_vsync = 0.
  - Because the history register resets to 0, vsync held low across reset release produces no frame start.
  - out_frame_start is registered: high the cycle after the falling edge is seen.
- On each frame start, in the same cycle:
  - Active mode <= in_mode.
  - out_frame_cnt increments, wrapping 0xFFFF -> 0.
  - Divider increments. When it reaches CURSOR_FRAMES-1 it clears to 0 and the cursor steps.
- Cursor step:
  - x = x+1.
  - When x = 59: x <= 0 and y <= y+1.
  - When x = 59 and y = 33: both return to 0.
  - y never exceeds 33; the cursor never leaves the tile grid.
- Blanking: RGB = 0 when stage-1 en = 0, x >= H_ACTIVE, or y >= V_ACTIVE.
- Mode 0, checker:
  - r = (x[3]^y[3]) ? 15 : 0.
  - g = (x[4]^y[4]) ? 15 : 0.
  - b = (x[5]^y[5]) ? 15 : 0.
- Mode 1, colour bars:
  - 8 bars, each 60 px wide; bar = x/60, implemented as a compare chain with no divider.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full scale values: r = 31, g = 63, b = 31.
- Mode 2, gradient: r = x[8:4], g = y[8:3], b = ~x[8:4].
- Mode 3: black background.
- Cursor overlay (all modes, active pixels only): pixel with x[9:3] = cursor_x and y[9:3] = cursor_y is forced to r = 31, g = 0, b = 0.
- Mode timing:
  - A mode change mid-frame has no effect until the next frame start.
  - A frame start and a mode change in the same cycle take the new in_mode.
- Reset mid-frame: outputs go to reset values immediately; no partial-frame state survives.

Decomposition:
- Package lcd_pkg holds:
  - H_ACTIVE, V_ACTIVE, TILE_COLS = 60, TILE_ROWS = 34, TILE_LOG2 = 3.
  - Mode encodings MODE_CHECKER, MODE_BARS, MODE_GRAD, MODE_BLACK.
  - The 8-entry bar RGB565 colour table.
  - The cursor colour.
- Sub-module lcd_tile_cursor contains:
  - The frame-start edge detector.
  - The frame counter and divider.
  - The cursor stepping.
- The top instantiates lcd_tile_cursor next to the pattern/pipeline logic.

Test Plan:
- Latency check: release reset, drive one active line with in_en high for x = 0..479 -> out_en and out_hsync equal inputs delayed exactly 2 cycles; RGB is 0 wherever the delayed en is 0.
- Mode 1: mode=1 then one frame start; sample x = 0, 59, 60, 420 at y = 100 -> RGB565 = FFFF, FFFF, FFE0, 0000 (x = 60 is yellow, x = 420 is black).
- Mode 0, cursor at (0,0): x = 8, y = 0 -> r = 15, g = 0, b = 0; x = 3, y = 3 -> r = 31, g = 0, b = 0 (overlay).
- Cursor wrap, CURSOR_FRAMES = 1: apply 59 frame starts -> cursor (59,0); one more -> (0,1); after 2040 total -> (0,0); out_frame_cnt = 2040.
- Mode change mid-frame: in_mode 0 -> 2 at line 100 -> output remains checker until the next vsync falling edge, then becomes gradient.
- Reset robustness: hold vsync low while releasing in_rst_n -> no out_frame_start. Assert in_rst_n mid-line -> outputs at reset values within the same cycle (async).
